// File: rtl/resp_pkg.sv
// Shared definitions for the handshake responder: FSM encoding, default sizing, count width helper.
package resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        STALL = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam int DEF_DW        = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_ACK_DELAY = 3;

    // Count must reach DEPTH itself, hence one bit beyond the address width.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/handshake_responder_if.sv
// Sender/drain side bundle of the handshake responder; data_par/par_err exist only with RESP_PARITY_EN.
interface handshake_responder_if #(
    parameter int DW    = resp_pkg::DEF_DW,
    parameter int DEPTH = resp_pkg::DEF_DEPTH
) ();

    localparam int CW = resp_pkg::cnt_w(DEPTH);

    logic          validdata;
    logic [DW-1:0] data_in;
    logic          acknowledge;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          proto_err;
`ifdef RESP_PARITY_EN
    logic          data_par;
    logic          par_err;
`endif

    modport master (
`ifdef RESP_PARITY_EN
        output data_par,
        input  par_err,
`endif
        output validdata, data_in, rd_en,
        input  acknowledge, data_out, empty, full, count, proto_err
    );

    modport slave (
`ifdef RESP_PARITY_EN
        input  data_par,
        output par_err,
`endif
        input  validdata, data_in, rd_en,
        output acknowledge, data_out, empty, full, count, proto_err
    );

endinterface

// File: rtl/resp_fifo.sv
// Show-ahead word FIFO; rd_dat reads 0 when empty.
// Latency: write visible on rd_dat the cycle after wr_en; count updates same edge.
// Backpressure: writes while full are dropped unless a read frees the slot in the same cycle.
module resp_fifo
    import resp_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DW-1:0]           wr_dat,
    input  logic                    rd_en,
    output logic [DW-1:0]           rd_dat,
    output logic                    empty,
    output logic                    full,
    output logic [cnt_w(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_rd;
    logic          do_wr;

    // Pointers carry one wrap bit so full and empty stay distinguishable.
    assign count  = wr_ptr - rd_ptr;
    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign do_rd  = rd_en && !empty;
    assign do_wr  = wr_en && (!full || do_rd);
    assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/handshake_responder.sv
// Captures one-pulse validdata words, holds them ACK_DELAY cycles, stores them and pulses acknowledge.
// Latency: validdata at edge N -> FIFO write and acknowledge high from edge N+1+ACK_DELAY, one cycle.
// Backpressure: full FIFO parks the word in STALL and withholds acknowledge; RESP_PARITY_EN adds parity drop.
module handshake_responder
    import resp_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ACK_DELAY = DEF_ACK_DELAY
) (
    input  logic                  clk,
    input  logic                  rst,
    handshake_responder_if.slave  bus
);

    state_t                  state_q;
    state_t                  state_d;
    logic [DW-1:0]           hold_reg;
    logic [7:0]              dly_cnt;
    logic                    hold_bad;
    logic                    space;
    logic                    fifo_wr;
    logic                    ack_q;
    logic                    proto_err_q;
    logic [DW-1:0]           fifo_dat;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [cnt_w(DEPTH)-1:0] fifo_count;

    // A word that will be discarded never needs room, so it is acknowledged without stalling.
    assign space = !fifo_full || bus.rd_en || hold_bad;

    always_comb begin
        state_d = state_q;
        fifo_wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.validdata) state_d = DELAY;
            end
            DELAY: begin
                if (dly_cnt == 8'd0) begin
                    if (space) begin
                        fifo_wr = !hold_bad;
                        state_d = ACK;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (space) begin
                    fifo_wr = !hold_bad;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            dly_cnt     <= 8'd0;
            hold_reg    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == ACK);
            if (state_q == IDLE && bus.validdata) begin
                hold_reg <= bus.data_in;
                dly_cnt  <= 8'(ACK_DELAY);
            end else if (state_q == DELAY && dly_cnt != 8'd0) begin
                dly_cnt <= dly_cnt - 8'd1;
            end
            if (state_q != IDLE && bus.validdata) proto_err_q <= 1'b1;
        end
    end

`ifdef RESP_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_bad  <= 1'b0;
            par_err_q <= 1'b0;
        end else if (state_q == IDLE && bus.validdata) begin
            hold_bad <= ^{bus.data_in, bus.data_par};
            if (^{bus.data_in, bus.data_par}) par_err_q <= 1'b1;
        end
    end

    assign bus.par_err = par_err_q;
`else
    assign hold_bad = 1'b0;
`endif

    resp_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (fifo_wr),
        .wr_dat (hold_reg),
        .rd_en  (bus.rd_en),
        .rd_dat (fifo_dat),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_count)
    );

    assign bus.acknowledge = ack_q;
    assign bus.proto_err   = proto_err_q;
    assign bus.data_out    = fifo_dat;
    assign bus.empty       = fifo_empty;
    assign bus.full        = fifo_full;
    assign bus.count       = fifo_count;

endmodule

// File: tb/tb_handshake_responder.sv
// Directed bench: stimulus pushes expected ack records, a negedge monitor pops and compares on each acknowledge.
module tb_handshake_responder;

    localparam int DW        = 8;
    localparam int DEPTH     = 4;
    localparam int ACK_DELAY = 3;

    typedef struct {
        int         cyc;
        int         cnt;
        logic [7:0] head;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    handshake_responder_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    handshake_responder #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .ACK_DELAY (ACK_DELAY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h) at cyc %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every acknowledge must match the oldest expected record.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.acknowledge) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                e = q.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_count", 32'(bus.count), e.cnt);
                chk("ack_head", 32'(bus.data_out), 32'(e.head));
            end
        end
    end

    task automatic pulse(input logic [7:0] d, input bit par_ok, input bit push, input int cnt, input logic [7:0] head);
        exp_t e;
        @(negedge clk);
        bus.validdata = 1'b1;
        bus.data_in   = d;
`ifdef RESP_PARITY_EN
        bus.data_par  = par_ok ? ^d : ~(^d);
`endif
        if (push) begin
            e.cyc  = cyc + 2 + ACK_DELAY;
            e.cnt  = cnt;
            e.head = head;
            q.push_back(e);
        end
        @(negedge clk);
        bus.validdata = 1'b0;
        bus.data_in   = 8'h00;
    endtask

    task automatic pop_word(input logic [7:0] exp_head);
        @(negedge clk);
        chk("pop_head", 32'(bus.data_out), 32'(exp_head));
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("ack_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        bus.validdata = 1'b0;
        bus.data_in   = 8'h00;
        bus.rd_en     = 1'b0;
`ifdef RESP_PARITY_EN
        bus.data_par  = 1'b0;
`endif
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ack", 32'(bus.acknowledge), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_data_out", 32'(bus.data_out), 0);
        chk("rst_proto_err", 32'(bus.proto_err), 0);

        // Single word: ack exactly 1+ACK_DELAY edges after the sampling edge.
        pulse(8'hA5, 1'b1, 1'b1, 1, 8'hA5);
        wait_drain(20);
        chk("t1_count", 32'(bus.count), 1);
        chk("t1_empty", 32'(bus.empty), 0);
        chk("t1_data_out", 32'(bus.data_out), 32'h A5);
        pop_word(8'hA5);
        chk("t1_empty_after_pop", 32'(bus.empty), 1);

        // Fill to full, then a fifth word must stall until a read makes room.
        pulse(8'h11, 1'b1, 1'b1, 1, 8'h11); wait_drain(20);
        pulse(8'h22, 1'b1, 1'b1, 2, 8'h11); wait_drain(20);
        pulse(8'h33, 1'b1, 1'b1, 3, 8'h11); wait_drain(20);
        pulse(8'h44, 1'b1, 1'b1, 4, 8'h11); wait_drain(20);
        chk("t2_full", 32'(bus.full), 1);
        pulse(8'h55, 1'b1, 1'b0, 0, 8'h00);
        idle(10);
        chk("t2_stall_count", 32'(bus.count), 4);
        @(negedge clk);
        bus.rd_en = 1'b1;
        e.cyc  = cyc + 1;
        e.cnt  = 4;
        e.head = 8'h22;
        q.push_back(e);
        @(negedge clk);
        bus.rd_en = 1'b0;
        wait_drain(5);
        chk("t2_full_after", 32'(bus.full), 1);
        pop_word(8'h22);
        pop_word(8'h33);
        pop_word(8'h44);
        pop_word(8'h55);
        chk("t2_drained", 32'(bus.count), 0);

        // Back-to-back pulses: second lands in DELAY and is dropped.
        pulse(8'h5A, 1'b1, 1'b1, 1, 8'h5A);
        pulse(8'hC3, 1'b1, 1'b0, 0, 8'h00);
        wait_drain(20);
        idle(8);
        chk("t3_proto_err", 32'(bus.proto_err), 1);
        chk("t3_count", 32'(bus.count), 1);
        pop_word(8'h5A);

        // Reset mid-transfer discards the pending word and clears the sticky error.
        pulse(8'h77, 1'b1, 1'b0, 0, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(10);
        chk("t4_count", 32'(bus.count), 0);
        chk("t4_proto_err", 32'(bus.proto_err), 0);
        chk("t4_empty", 32'(bus.empty), 1);

        // Read on empty is a no-op; read and write in the same cycle keep count.
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk("t5_empty_rd_count", 32'(bus.count), 0);
        chk("t5_empty_rd_data", 32'(bus.data_out), 0);
        pulse(8'hD1, 1'b1, 1'b1, 1, 8'hD1); wait_drain(20);
        pulse(8'hD2, 1'b1, 1'b1, 2, 8'hD1); wait_drain(20);
        pulse(8'hD3, 1'b1, 1'b1, 2, 8'hD2);
        idle(ACK_DELAY);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        wait_drain(5);
        chk("t5_simul_count", 32'(bus.count), 2);
        pop_word(8'hD2);
        pop_word(8'hD3);
        chk("t5_final_empty", 32'(bus.empty), 1);

`ifdef RESP_PARITY_EN
        chk("t6_par_err_clear", 32'(bus.par_err), 0);
        pulse(8'h01, 1'b0, 1'b1, 0, 8'h00);
        wait_drain(20);
        chk("t6_par_err", 32'(bus.par_err), 1);
        chk("t6_count", 32'(bus.count), 0);
`endif

        idle(5);
        chk("queue_empty_at_end", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got cyc %0d want finish before limit", cyc);
        $fatal(1);
    end

endmodule
